// File: rtl/round_ctrl.sv
// Per-round controller for the tug-of-war game: arm, random dark delay, lights on, resolve first push.
// Define ROUND_LFSR_EN to add a 16-bit LFSR term to the dark delay; otherwise the delay is DELAY_MIN.
module round_ctrl #(
  parameter int DELAY_MIN = 8,
  parameter int RAND_W    = 4,
  parameter int LIGHT_MAX = 16,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pb_l,
  input  logic i_pb_r,
  input  logic i_victory,
  output logic o_winrnd,
  output logic o_right,
  output logic o_tie,
  output logic o_leds_on
);

  typedef enum logic [2:0] {
    S_ARM   = 3'd0,
    S_WAIT  = 3'd1,
    S_LIT   = 3'd2,
    S_SCORE = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LIGHT = CNT_W'(LIGHT_MAX);

  if (DELAY_MIN < 1 || RAND_W < 1 || RAND_W > 16 || LIGHT_MAX < 1) begin : g_param_check
    $error("round_ctrl: parameter out of range");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_delay;
  logic             w_push;
  logic             w_cnt_one;
  logic             w_arm;
  logic             w_winrnd_next;
  logic             w_right_next;
  logic             w_tie_next;
  logic             w_leds_next;

`ifdef ROUND_LFSR_EN
  logic [15:0] r_lfsr;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  assign w_delay = CNT_W'(DELAY_MIN) + CNT_W'(r_lfsr[RAND_W-1:0]);
`else
  assign w_delay = CNT_W'(DELAY_MIN);
`endif

  assign w_push    = i_pb_l | i_pb_r;
  assign w_cnt_one = (r_cnt == C_ONE);
  assign w_arm     = ~i_pb_l & ~i_pb_r & ~i_victory;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_ARM;
      r_cnt     <= '0;
      o_winrnd  <= 1'b0;
      o_right   <= 1'b0;
      o_tie     <= 1'b0;
      o_leds_on <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      o_winrnd  <= w_winrnd_next;
      o_right   <= w_right_next;
      o_tie     <= w_tie_next;
      o_leds_on <= w_leds_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_ARM: begin
        if (w_arm) begin
          w_state_next = S_WAIT;
          w_cnt_next   = w_delay;
        end
      end
      S_WAIT: begin
        if (w_push) begin
          w_state_next = S_SCORE;
        end else if (w_cnt_one) begin
          w_state_next = S_LIT;
          w_cnt_next   = C_LIGHT;
        end else begin
          w_cnt_next = r_cnt - C_ONE;
        end
      end
      S_LIT: begin
        if (w_push) begin
          w_state_next = S_SCORE;
        end else if (w_cnt_one) begin
          w_state_next = S_ARM;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - C_ONE;
        end
      end
      S_SCORE: w_state_next = S_HOLD;
      S_HOLD: begin
        if (~i_pb_l & ~i_pb_r) w_state_next = S_ARM;
      end
      default: begin
        w_state_next = S_ARM;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are computed one cycle ahead so the registered values line up with the state
  always_comb begin
    w_winrnd_next = 1'b0;
    w_right_next  = 1'b0;
    w_tie_next    = 1'b0;
    w_leds_next   = 1'b0;
    case (r_state)
      S_WAIT: begin
        w_winrnd_next = w_push;
        w_right_next  = i_pb_r & ~i_pb_l;
        w_tie_next    = i_pb_r & i_pb_l;
        w_leds_next   = ~w_push & w_cnt_one;
      end
      S_LIT: begin
        w_winrnd_next = w_push;
        w_right_next  = i_pb_r & ~i_pb_l;
        w_tie_next    = i_pb_r & i_pb_l;
        w_leds_next   = w_push | ~w_cnt_one;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl: arming, dark delay, jump, tie, timeout, victory, hold and reset.
// Define ROUND_LFSR_EN (for both bench and RTL) to also check the random dark delay.
module tb_round_ctrl;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic pb_l    = 1'b0;
  logic pb_r    = 1'b0;
  logic victory = 1'b0;
  logic winrnd;
  logic right;
  logic tie;
  logic leds_on;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic saw;

  always #5 clk = ~clk;

  round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_pb_l    (pb_l),
    .i_pb_r    (pb_r),
    .i_victory (victory),
    .o_winrnd  (winrnd),
    .o_right   (right),
    .o_tie     (tie),
    .o_leds_on (leds_on)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %s = %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

`ifdef ROUND_LFSR_EN
  // Reference LFSR: new bit 15 is the XOR of taps at x^16, x^14, x^13, x^11
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | {fb, 15'd0};
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    tick();
    check_eq("rst_winrnd", winrnd, 0);
    check_eq("rst_right", right, 0);
    check_eq("rst_tie", tie, 0);
    check_eq("rst_leds", leds_on, 0);
    #2 rst_n = 1'b1;

    // 1: arm, 8 dark cycles, lights, right push
    tick();
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw |= leds_on;
      tick();
    end
    check_eq("s1_dark_8", saw, 0);
    check_eq("s1_lit_on_9", leds_on, 1);
    check_eq("s1_no_win_yet", winrnd, 0);
    pb_r = 1'b1;
    tick();
    check_eq("s1_winrnd", winrnd, 1);
    check_eq("s1_right", right, 1);
    check_eq("s1_tie", tie, 0);
    check_eq("s1_leds", leds_on, 1);
    pb_r = 1'b0;
    tick();
    check_eq("s1_hold_winrnd", winrnd, 0);
    check_eq("s1_hold_right", right, 0);
    check_eq("s1_hold_leds", leds_on, 0);
    ticks(2);

    // 2: jump on 3rd WAIT cycle
    ticks(2);
    pb_l = 1'b1;
    tick();
    check_eq("s2_winrnd", winrnd, 1);
    check_eq("s2_right", right, 0);
    check_eq("s2_tie", tie, 0);
    check_eq("s2_leds", leds_on, 0);
    pb_l = 1'b0;
    tick();
    check_eq("s2_hold_winrnd", winrnd, 0);
    check_eq("s2_hold_leds", leds_on, 0);
    ticks(2);

    // 3: tie in LIT
    ticks(8);
    check_eq("s3_lit", leds_on, 1);
    pb_l = 1'b1;
    pb_r = 1'b1;
    tick();
    check_eq("s3_winrnd", winrnd, 1);
    check_eq("s3_tie", tie, 1);
    check_eq("s3_right", right, 0);
    check_eq("s3_leds", leds_on, 1);

    // 5a: buttons held after SCORE keep the block in HOLD
    tick();
    check_eq("s5_hold_winrnd", winrnd, 0);
    check_eq("s5_hold_tie", tie, 0);
    check_eq("s5_hold_leds", leds_on, 0);
    saw = 1'b0;
    repeat (5) begin
      tick();
      saw |= winrnd | leds_on;
    end
    check_eq("s5_hold_quiet", saw, 0);
    pb_l = 1'b0;
    pb_r = 1'b0;
    ticks(9);
    check_eq("s5_release_dark", leds_on, 0);
    tick();
    check_eq("s5_release_lit", leds_on, 1);

    // 4: lights-on timeout, no point, re-arm
    saw = 1'b0;
    repeat (15) begin
      tick();
      saw |= winrnd;
    end
    check_eq("s4_lit_15", leds_on, 1);
    tick();
    saw |= winrnd;
    check_eq("s4_timeout_leds", leds_on, 0);
    check_eq("s4_timeout_nowin", saw, 0);
    ticks(8);
    check_eq("s4_rearm_dark", leds_on, 0);
    tick();
    check_eq("s4_rearm_lit", leds_on, 1);

    // 4b: victory mid-round does not abort, then blocks arming
    victory = 1'b1;
    pb_l = 1'b1;
    tick();
    check_eq("s4_vic_midround_win", winrnd, 1);
    check_eq("s4_vic_midround_right", right, 0);
    pb_l = 1'b0;
    ticks(2);
    saw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      pb_r = (k == 10);
      tick();
      saw |= leds_on | winrnd;
    end
    check_eq("s4_vic_stays_arm", saw, 0);
    victory = 1'b0;
    ticks(8);
    check_eq("s4_vic_clear_dark", leds_on, 0);
    tick();
    check_eq("s4_vic_clear_lit", leds_on, 1);

    // 5b: asynchronous reset during the winrnd cycle
    pb_r = 1'b1;
    tick();
    check_eq("s5_pre_reset_win", winrnd, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("s5_async_winrnd", winrnd, 0);
    check_eq("s5_async_right", right, 0);
    check_eq("s5_async_leds", leds_on, 0);
    pb_r = 1'b0;
    tick();
    check_eq("s5_in_reset_winrnd", winrnd, 0);
    #2 rst_n = 1'b1;
    tick();
    ticks(7);
    check_eq("s5_restart_dark", leds_on, 0);
    tick();
    check_eq("s5_restart_lit", leds_on, 1);

`ifdef ROUND_LFSR_EN
    // 6: random dark delay against the reference LFSR
    begin
      int exp_d;
      int n;
      int first_d;
      logic all_eq;
      all_eq = 1'b1;
      first_d = -1;
      pb_r = 1'b1;
      tick();
      pb_r = 1'b0;
      ticks(2);
      for (int r = 0; r < 8; r++) begin
        tick();
        exp_d = 8 + int'(m_prev[3:0]);
        n = 0;
        while (!leds_on && n < 40) begin
          tick();
          n++;
        end
        check_eq("s6_wait_len", n, exp_d);
        check_eq("s6_wait_range", (n >= 8 && n <= 23), 1);
        if (first_d < 0) first_d = n;
        else if (n != first_d) all_eq = 1'b0;
        pb_r = 1'b1;
        tick();
        pb_r = 1'b0;
        ticks(2);
      end
      check_eq("s6_not_all_equal", all_eq, 0);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
